// File: rtl/tx_chksum_input_arbiter.sv
// Packet-granular round-robin arbiter feeding the TX checksum stage from NUM_SRC AXI-stream producers.
// Optional per-source packet counters are enabled with `define TX_CHKSUM_ARB_PKT_CNT_EN.
module tx_chksum_input_arbiter #(
  parameter int NUM_SRC    = 2,
  parameter int DATA_WIDTH = 256,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int SRC_ID_W   = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic                           clk,
  input  logic                           rst,
`ifdef TX_CHKSUM_ARB_PKT_CNT_EN
  output logic [NUM_SRC*16-1:0]          pkt_cnt,
`endif
  input  logic [NUM_SRC-1:0]             src_tvalid,
  output logic [NUM_SRC-1:0]             src_tready,
  input  logic [NUM_SRC*DATA_WIDTH-1:0]  src_tdata,
  input  logic [NUM_SRC*KEEP_WIDTH-1:0]  src_tkeep,
  input  logic [NUM_SRC-1:0]             src_tlast,
  output logic                           out_tvalid,
  input  logic                           out_tready,
  output logic [DATA_WIDTH-1:0]          out_tdata,
  output logic [KEEP_WIDTH-1:0]          out_tkeep,
  output logic                           out_tlast,
  output logic [SRC_ID_W-1:0]            out_src_id
);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t              state, state_nxt;
  logic [SRC_ID_W-1:0] grant_reg, grant_nxt;
  logic [SRC_ID_W-1:0] rr_ptr, rr_nxt;
  logic [SRC_ID_W-1:0] winner, sel;
  logic                win_found, active, hs;

  logic [DATA_WIDTH-1:0] data_arr [NUM_SRC];
  logic [KEEP_WIDTH-1:0] keep_arr [NUM_SRC];

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_unpack
    assign data_arr[i] = src_tdata[i*DATA_WIDTH +: DATA_WIDTH];
    assign keep_arr[i] = src_tkeep[i*KEEP_WIDTH +: KEEP_WIDTH];
  end

  function automatic logic [SRC_ID_W-1:0] next_id(input logic [SRC_ID_W-1:0] id);
    if (id == SRC_ID_W'(NUM_SRC - 1))
      return '0;
    else
      return id + SRC_ID_W'(1);
  endfunction

  // Rotating priority scan starting at rr_ptr; the index wraps explicitly so non-power-of-two counts work.
  always_comb begin
    logic [SRC_ID_W:0]   sum;
    logic [SRC_ID_W-1:0] idx;
    win_found = 1'b0;
    winner    = rr_ptr;
    sum       = '0;
    idx       = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      sum = {1'b0, rr_ptr} + (SRC_ID_W+1)'(k);
      if (sum >= (SRC_ID_W+1)'(NUM_SRC))
        sum = sum - (SRC_ID_W+1)'(NUM_SRC);
      idx = sum[SRC_ID_W-1:0];
      if (!win_found && src_tvalid[idx]) begin
        win_found = 1'b1;
        winner    = idx;
      end
    end
  end

  always_comb begin
    state_nxt  = state;
    grant_nxt  = grant_reg;
    rr_nxt     = rr_ptr;
    src_tready = '0;
    out_tdata  = '0;
    out_tkeep  = '0;
    out_tlast  = 1'b0;
    out_tvalid = 1'b0;
    sel        = (state == LOCKED) ? grant_reg : winner;
    active     = !rst && ((state == LOCKED) || win_found);
    out_src_id = rst ? '0 : sel;
    if (active) begin
      out_tvalid      = src_tvalid[sel];
      out_tdata       = data_arr[sel];
      out_tkeep       = keep_arr[sel];
      out_tlast       = src_tlast[sel];
      src_tready[sel] = out_tready;
    end
    hs = out_tvalid && out_tready;
    // Any offered first beat locks the grant, even under backpressure, so the beat stays stable.
    case (state)
      IDLE: begin
        if (win_found) begin
          grant_nxt = winner;
          if (hs && out_tlast)
            rr_nxt = next_id(winner);
          else
            state_nxt = LOCKED;
        end
      end
      LOCKED: begin
        if (hs && out_tlast) begin
          state_nxt = IDLE;
          rr_nxt    = next_id(grant_reg);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      grant_reg <= '0;
      rr_ptr    <= '0;
    end else begin
      state     <= state_nxt;
      grant_reg <= grant_nxt;
      rr_ptr    <= rr_nxt;
    end
  end

`ifdef TX_CHKSUM_ARB_PKT_CNT_EN
  logic [15:0] cnt_q [NUM_SRC];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_SRC; i++)
        cnt_q[i] <= '0;
    end else if (hs && out_tlast) begin
      cnt_q[sel] <= cnt_q[sel] + 16'd1;
    end
  end

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_cnt
    assign pkt_cnt[i*16 +: 16] = cnt_q[i];
  end
`endif

endmodule
